// File: rtl/mult_pkg.sv
// Shared definitions for the sequential MULT/MULTU unit.
//   - state_e      : control state of the iterative multiplier
//   - MULT_WIDTH   : operand width (product is 2*MULT_WIDTH)
//   - MULT_CNT_W   : step counter width, 2**MULT_CNT_W > MULT_WIDTH
//   - MULT_LATENCY : start-accept to done latency, in cycles, with early termination disabled
package mult_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_CNT_W   = 6;
  localparam int MULT_LATENCY = MULT_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/add32_co.sv
// Ripple-free behavioural adder with carry-out, used for the partial-product
// accumulation step of mult32_seq.
// Ports:
//   a, b      : WIDTH-bit addends
//   carry_in  : carry into bit 0
//   sum       : WIDTH-bit sum
//   carry_out : carry out of the top bit (bit WIDTH of the full sum)
module add32_co #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule

// File: rtl/mult32_seq.sv
// Iterative radix-2 shift-add multiplier for MIPS MULT/MULTU.
// Operands are converted to magnitudes at acceptance, multiplied unsigned one
// bit per cycle, and the 64-bit result is negated in a final fix-up cycle when
// the operand signs differ.
//
// Optional build macro: MULT32_EARLY_TERM_EN
//   When defined, CALC finishes as soon as the unexamined multiplier bits are
//   all zero, shifting the remaining distance in one cycle. Results are
//   identical; only latency shrinks.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a multiply (accepted only in IDLE, flush wins)
//   is_signed    : 1 = MULT, 0 = MULTU; sampled with start
//   src_a, src_b : multiplicand / multiplier; sampled with start
//   flush        : abort current operation, return to IDLE, no done
//   busy         : high while in CALC or FIX
//   done         : one-cycle pulse, hi/lo valid in the same cycle
//   hi, lo       : upper / lower product words, held until next completion
module mult32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   add_sum;
  logic               add_co;
  logic [2*WIDTH-1:0] prod_cur;
  logic [2*WIDTH-1:0] prod_fix;

  // Partial product: add the multiplicand only when the current multiplier bit is set.
  assign add_b    = mcand_q & {WIDTH{mplier_q[0]}};
  assign prod_cur = {acc_q, mplier_q};
  assign prod_fix = neg_q ? ('0 - prod_cur) : prod_cur;

  add32_co #(.WIDTH(WIDTH)) u_add (
    .a         (acc_q),
    .b         (add_b),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_co)
  );

`ifdef MULT32_EARLY_TERM_EN
  // Low (WIDTH-cnt) bits of mplier are still unexamined; shifting left by cnt
  // discards the product bits already shifted in and leaves only those.
  logic [WIDTH-1:0] rem_bits;
  logic [CNT_W:0]   rem_steps;
  assign rem_bits  = mplier_q << cnt_q;
  assign rem_steps = (CNT_W+1)'(WIDTH) - {1'b0, cnt_q};
`endif

  // NOTE: every variable gets its hold value first so no path through the
  // case statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = (is_signed && src_a[WIDTH-1]) ? ('0 - src_a) : src_a;
          mplier_d = (is_signed && src_b[WIDTH-1]) ? ('0 - src_b) : src_b;
          neg_d    = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        // {sum, mplier} >> 1: carry-out becomes the new acc MSB and the sum LSB
        // drops into the vacated multiplier MSB.
        acc_d    = {add_co, add_sum[WIDTH-1:1]};
        mplier_d = {add_sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end
`ifdef MULT32_EARLY_TERM_EN
        if (rem_bits == '0) begin
          {acc_d, mplier_d} = prod_cur >> rem_steps;
          state_d           = FIX;
        end
`endif
      end
      FIX: begin
        {acc_d, mplier_d} = prod_fix;
        {hi_d, lo_d}      = prod_fix;
        state_d           = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush overrides everything: drop back to IDLE and leave hi/lo untouched.
    if (flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed corner cases plus randomized
// operands compared against a plain 64-bit arithmetic reference.
module tb_mult32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          errors;
  logic [63:0] last_prod;

  mult32_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'h0, a} * {32'h0, b};
  endfunction

  function automatic int exp_latency(input logic [31:0] b, input logic s);
`ifdef MULT32_EARLY_TERM_EN
    logic [31:0] m;
    int          h;
    m = (s && b[31]) ? (32'h0 - b) : b;
    if (m == 32'h0) return 3;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return ((h + 2 > 32) ? 32 : h + 2) + 2;
`else
    return 34;
`endif
  endfunction

  // Issue one operation, optionally inject an ignored start at cycle T+inj,
  // then wait for done and check latency, busy length and the product.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int inj, input logic [31:0] ia, input logic [31:0] ib);
    logic [63:0] exp;
    int          n;
    int          busy_n;
    int          lat;
    exp = model(a, b, s);
    lat = exp_latency(b, s);
    start = 1'b1; is_signed = s; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = $urandom; src_b = $urandom; is_signed = 1'($urandom);
    n = 1;
    busy_n = busy ? 1 : 0;
    while (!done && n < 200) begin
      if (inj > 0 && n == inj) begin
        start = 1'b1; src_a = ia; src_b = ib;
      end
      tick();
      start = 1'b0;
      n++;
      if (busy) busy_n++;
    end
    check("done_seen", 64'(done), 64'd1);
    check("latency", 64'(n), 64'(lat));
    check("busy_cycles", 64'(busy_n), 64'(lat - 1));
    check("hi", 64'(hi), 64'(exp[63:32]));
    check("lo", 64'(lo), 64'(exp[31:0]));
    last_prod = exp;
    tick();
    check("done_pulse_end", 64'(done), 64'd0);
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  // Watch for a stray done over a window and confirm hi/lo kept last_prod.
  task automatic expect_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check({tag, "_no_activity"}, 64'(seen), 64'd0);
    check({tag, "_hold"}, {hi, lo}, last_prod);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          fl;
    checks = 0; errors = 0; last_prod = '0;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    src_a = '0; src_b = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed products.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    check("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 0, 0, 0);
    check("mult_neg3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0);
    check("mult_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(32'h0000_0000, 32'h8000_0000, 1'b1, 0, 0, 0);
    check("mult_zero_neg", {hi, lo}, 64'h0);
    run_op(32'h1234_5678, 32'h0000_0000, 1'b0, 0, 0, 0);
    run_op(32'h0000_0007, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);

    // Second start while busy is ignored.
    run_op(32'h0001_0003, 32'h7654_3210, 1'b0, 5, 32'hDEAD_BEEF, 32'h0000_0099);

    // Flush mid-operation: no done, hi/lo keep the previous product.
    run_op(32'h0000_0011, 32'h0000_0013, 1'b0, 0, 0, 0);
    fl = (exp_latency(32'd6, 1'b0) > 12) ? 10 : 1;
    start = 1'b1; is_signed = 1'b0; src_a = 32'd5; src_b = 32'd6;
    tick();
    start = 1'b0;
    repeat (fl - 1) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    expect_quiet("flush");
    run_op(32'd5, 32'd6, 1'b0, 0, 0, 0);
    check("after_flush", {hi, lo}, 64'd30);

    // Flush and start together in IDLE: nothing starts.
    start = 1'b1; flush = 1'b1; src_a = 32'd9; src_b = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    expect_quiet("flush_start");

    // Asynchronous reset in the middle of an operation.
    run_op(32'hABCD_0001, 32'h0000_FFFF, 1'b0, 0, 0, 0);
    start = 1'b1; is_signed = 1'b0; src_a = 32'hFFFF_0000; src_b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    #4 rst_n = 1'b1;
    tick();
    run_op(32'd2, 32'd3, 1'b0, 0, 0, 0);
    check("after_arst", {hi, lo}, 64'd6);

    // Randomized operands, with extremes mixed in.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'h0000_0000;
        2: rb = rb >> $urandom_range(0, 31);
        3: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(ra, rb, 1'($urandom), 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult32_seq.md
Name: mult32_seq

Overview:
- Iterative radix-2 shift-add multiplier for the MIPS MULT/MULTU instructions in the EX stage of the pipelined CPU.
- Computes a 64-bit product into HI/LO over 32+ cycles. Each step's partial-product accumulation goes through a 32-bit adder sub-module with carry-out.
- Hazard logic stalls on busy and consumes hi/lo when done is asserted.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is verified.
- CNT_W, 6, width of the step counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request a multiply; accepted only in IDLE
- is_signed  in  1  1 = MULT (signed), 0 = MULTU; sampled with start
- src_a  in  WIDTH  multiplicand; sampled with start
- src_b  in  WIDTH  multiplier; sampled with start
- flush  in  1  abort the current operation (pipeline flush)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; hi/lo are valid in the same cycle
- hi  out  WIDTH  product[63:32], held until the next completion
- lo  out  WIDTH  product[31:0], held until the next completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; internal registers cleared.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start=1, flush=0:
  - Latch mcand=|src_a| and mplier=|src_b|. Absolute values are taken only when is_signed=1.
  - Latch neg = is_signed & (src_a[31]^src_b[31]).
  - acc=0, cnt=0; go to CALC.
- CALC, one step per cycle:
  - sum[32:0] = acc + (mplier[0] ? mcand : 0), via the adder sub-module (carry_in=0, carry_out used).
  - {acc, mplier} <= {sum, mplier} >> 1.
  - cnt++; after step WIDTH-1, go to FIX.
- FIX, one cycle: if neg, {acc, mplier} <= 0 - {acc, mplier} (64-bit two's complement); otherwise hold.
- DONE: hi<=acc and lo<=mplier on entry; done=1 for exactly one cycle; return to IDLE.
- Latency: start accepted at cycle T -> done at T+WIDTH+2 (34 for WIDTH=32). busy=1 from T+1 through T+WIDTH+1.
- Boundary and overlap rules:
  - |-2^31| = 2^31 is representable unsigned; no overflow path exists.
  - Zero result with neg=1 stays 0.
  - start while not IDLE is ignored; there is no queueing.
  - A new start is accepted in the cycle after done, i.e. in IDLE.
  - flush in any state: next state IDLE, busy=0, no done pulse, hi/lo unchanged.
  - flush and start in the same IDLE cycle: flush wins and start is dropped.
  - rst_n deasserted mid-operation: the operation is lost; all outputs return to reset values immediately.
- Inputs are sampled only at acceptance; src_a and src_b may change afterwards.

Optional Feature:
- Macro: MULT32_EARLY_TERM_EN.
- Defined:
  - In CALC, if the remaining mplier bits still to be examined are all zero, the remaining steps reduce to one aligned right shift of {acc, mplier} by (WIDTH-cnt) in a single cycle.
  - The block then proceeds to FIX, so latency is WIDTH_effective+2.
  - src_b=0 gives done at T+3.
- Undefined: fixed latency of WIDTH+2 cycles. Results are bit-identical in both builds.

Decomposition:
- Shared package mult_pkg:
  - state enum (IDLE, CALC, FIX, DONE)
  - MULT_WIDTH=32, MULT_CNT_W=6
  - MULT_LATENCY=34
- One sub-module: add32_co, a 32-bit adder with carry_out instantiated once for the CALC step.
- The FIX negation is plain RTL.

Test Plan:
- Unsigned: MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> done at T+34, hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- Signed: MULT src_a=0xFFFFFFFD (-3), src_b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also src_a=0x80000000, src_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- Zero sign case: MULT src_a=0, src_b=0x80000000 -> hi=0, lo=0. With MULT32_EARLY_TERM_EN and src_b=0, done at T+3.
- Flush: start MULTU 5*6, flush at step 10 -> no done pulse, busy=0 next cycle, hi/lo keep prior values. start next cycle -> hi=0, lo=30 after 34 cycles.
- start while busy: second start at step 5 with different operands is ignored; first result is delivered. Flush+start in the same IDLE cycle -> no operation starts.
- Async reset at step 20: outputs zero without a clock edge; after release, start 2*3 -> lo=6.
